pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised IF-stage program-counter generator; next generation of the single-issue PC register.
//  Drives instruction-ROM address and chip-enable to IF and IF/ID.
//  Adds: configurable reset vector/width/step, exception flush redirect, ROM-ready backpressure,
//  capture of branch requests that arrive during a stall, and misaligned-target flagging.
// PARAMETERS
//  ADDR_W       32            PC / address width in bits
//  RESET_VECTOR 32'h0000_0000 PC value held while ce_o is low and after reset
//  PC_INC       4             byte increment per sequential fetch
//  STALL_W      6             width of stall bus from ctrl; bit 0 freezes the PC
//  ALIGN_BITS   2             low address bits that must be zero in a redirect target
// PORTS
//  clk              in   1        single clock, rising edge
//  rst              in   1        asynchronous, active-high reset
//  stall            in   STALL_W  pipeline stall vector from ctrl; only stall[0] is used here
//  if_ready_i       in   1        ROM accepts the address on pc_o this cycle
//  flush_i          in   1        exception/eret flush from ctrl; highest priority
//  new_pc_i         in   ADDR_W   flush target
//  branch_flag_i    in   1        ID resolved a taken branch/jump (`Branch)
//  branch_target_i  in   ADDR_W   branch/jump target address
//  pc_o             out  ADDR_W   current fetch address
//  ce_o             out  1        ROM chip enable (`ChipEnable/`ChipDisable)
//  misalign_o       out  1        one-cycle pulse: redirect target had nonzero low ALIGN_BITS
// BEHAVIOUR
//  Reset (async, immediate): pc_o=RESET_VECTOR, ce_o=0, misalign_o=0, pend_valid=0, state=S_OFF.
//  FSM, state updates on clk:
//   S_OFF : ce_o=0, pc_o held at RESET_VECTOR. Next edge -> S_RUN, ce_o<=1, pc_o unchanged.
//           The first fetch is therefore RESET_VECTOR.
//   S_RUN : no pending redirect.
//   S_PEND: a redirect is latched in pend_addr.
//  adv = ce_o & (stall[0]==`NoStop) & if_ready_i.
//  Per-edge priority in S_RUN/S_PEND, highest first:
//   1 flush_i: pc_o<=new_pc_i at once, regardless of adv/stall.
//     Clears any pending redirect -> S_RUN.
//   2 branch_flag_i & adv: pc_o<=branch_target_i; a stale pending redirect is dropped -> S_RUN.
//   3 branch_flag_i & !adv: pend_addr<=branch_target_i, pend_valid<=1 -> S_PEND.
//     pc_o holds; a later branch overwrites pend_addr.
//   4 S_PEND & adv: pc_o<=pend_addr, pend_valid<=0 -> S_RUN.
//   5 adv: pc_o<=pc_o+PC_INC, modulo 2^ADDR_W (wraps to 0, no flag).
//   6 else: pc_o holds.
//  Redirect targets (new_pc_i, branch_target_i):
//   - Low ALIGN_BITS are forced to 0 before use/latching.
//   - misalign_o<=1 for exactly the following cycle if any forced bit was 1, else 0.
//  Latency: redirect visible on pc_o the edge after request when adv (or flush); sequential step 1 cycle.
//  Simultaneous flush & branch: flush wins, branch discarded.
//  Reset mid-operation drops any pending redirect.
//  ce_o is registered; it never depends combinationally on rst or inputs.
// STRUCTURE
//  Shared defines.v constants: RstEnable, ChipEnable/ChipDisable, NoStop/Stop, Branch/NotBranch, InstAddrBus.
//  Local state encodings S_OFF/S_RUN/S_PEND: localparam.
//  One sub-module: pc_redirect_buf.
//   - Holds pend_valid/pend_addr and the alignment masking.
//   - Inputs: set/clear/flush; output: masked addr + misalign bit.
//  The pc_gen top holds the FSM and the PC adder.
// TESTING
//  T1 rst=1 then release -> pc_o=RESET_VECTOR and ce_o=0 during reset.
//     Edge1: ce_o=1, pc 0x0. Edges 2-4: pc 0x4, 0x8, 0xC.
//  T2 running at 0x10, stall=6'b000001 for 3 cycles -> pc_o holds 0x10.
//     Release -> 0x14 next edge.
//  T3 at 0x20, branch_flag_i=1, target 0x100, stall[0]=1 for 2 cycles -> pc_o holds 0x20.
//     Release -> pc_o=0x100, then 0x104.
//  T4 same cycle: flush_i=1/new_pc_i=0x180 and branch_flag_i=1/0x200, with if_ready_i=0.
//     -> pc_o=0x180, pend_valid=0, no later jump to 0x200.
//  T5 branch target 0x103 with adv=1 -> pc_o=0x100, misalign_o=1 for one cycle, then 0.
//     Check PC_INC wrap: pc 0xFFFF_FFFC -> 0x0.
//  T6 assert rst for 1 cycle while in S_PEND.
//     -> pc_o=RESET_VECTOR, ce_o=0 at once; pending target never fetched after release.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the IF-stage program-counter generator.
package pc_gen_pkg;

  // Control-level encodings shared with the rest of the pipeline
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic NO_STOP      = 1'b0;
  localparam logic BRANCH       = 1'b1;

  // Default instruction address bus width
  localparam int INST_ADDR_W = 32;

  // S_OFF: fetch disabled, S_RUN: fetching, S_PEND: a redirect waits for the ROM/stall
  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Alignment masking of redirect targets and the single-entry pending-redirect buffer.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W     = INST_ADDR_W,
  parameter int ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              set_i,
  input  logic              clear_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] tgt_addr_o,
  output logic              tgt_misalign_o,
  output logic              pend_valid_o,
  output logic [ADDR_W-1:0] pend_addr_o
);

  localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1);

  logic [ADDR_W-1:0] raw_tgt;
  logic              pend_valid_d, pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_d, pend_addr_q;

  // Pick the redirect source (flush wins) and force its low bits to zero
  always_comb begin
    raw_tgt        = sel_flush_i ? new_pc_i : branch_target_i;
    tgt_addr_o     = raw_tgt & ~LOW_MASK;
    tgt_misalign_o = |(raw_tgt & LOW_MASK);
  end

  // Next pending state: a flush discards, a new capture overwrites, a consume clears
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (flush_i) begin
      pend_valid_d = 1'b0;
    end else if (set_i) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = tgt_addr_o;
    end else if (clear_i) begin
      pend_valid_d = 1'b0;
    end
  end

  // Pending-redirect registers; reset drops anything captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign pend_valid_o = pend_valid_q;
  assign pend_addr_o  = pend_addr_q;

endmodule

// File: rtl/pc_gen.sv
// IF-stage PC generator: enable FSM, sequential adder and redirect priority logic.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W       = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                PC_INC       = 4,
  parameter int                STALL_W      = 6,
  parameter int                ALIGN_BITS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               if_ready_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  new_pc_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               ce_o,
  output logic               misalign_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  pc_state_e         state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              ce_d, ce_q;
  logic              misalign_d, misalign_q;
  logic              adv;
  logic              running;
  logic              buf_set, buf_clear, buf_flush;
  logic [ADDR_W-1:0] tgt_addr;
  logic              tgt_misalign;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              unused_stall;

  // Only stall[0] freezes the PC; the upper bits belong to later stages
  assign unused_stall = ^stall;

  pc_redirect_buf #(
    .ADDR_W     (ADDR_W),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_redirect_buf (
    .clk             (clk),
    .rst             (rst),
    .sel_flush_i     (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_target_i (branch_target_i),
    .set_i           (buf_set),
    .clear_i         (buf_clear),
    .flush_i         (buf_flush),
    .tgt_addr_o      (tgt_addr),
    .tgt_misalign_o  (tgt_misalign),
    .pend_valid_o    (pend_valid),
    .pend_addr_o     (pend_addr)
  );

  // Fetch advances only when enabled, not frozen, and the ROM takes the address
  always_comb begin
    running = (state_q != S_OFF);
    adv     = (ce_q == CHIP_ENABLE) && (stall[0] == NO_STOP) && if_ready_i;
  end

  // Next-PC selection in priority order: flush, branch, capture, pending, step, hold
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    misalign_d = 1'b0;
    buf_set    = 1'b0;
    buf_clear  = 1'b0;
    buf_flush  = 1'b0;
    if (!running) begin
      state_d = S_RUN;
      ce_d    = CHIP_ENABLE;
    end else if (flush_i) begin
      pc_d       = tgt_addr;
      misalign_d = tgt_misalign;
      buf_flush  = 1'b1;
      state_d    = S_RUN;
    end else if ((branch_flag_i == BRANCH) && adv) begin
      pc_d       = tgt_addr;
      misalign_d = tgt_misalign;
      buf_clear  = 1'b1;
      state_d    = S_RUN;
    end else if (branch_flag_i == BRANCH) begin
      misalign_d = tgt_misalign;
      buf_set    = 1'b1;
      state_d    = S_PEND;
    end else if (pend_valid && adv) begin
      pc_d      = pend_addr;
      buf_clear = 1'b1;
      state_d   = S_RUN;
    end else if (adv) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // State, PC and registered outputs; reset returns to the disabled reset vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      pc_q       <= RESET_VECTOR;
      ce_q       <= CHIP_DISABLE;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen against a behavioural fetch-address model.
module tb_pc_gen;

  localparam int          ADDR_W       = 32;
  localparam int          STALL_W      = 6;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          PC_INC       = 4;
  localparam int          ALIGN_BITS   = 2;
  localparam int          ALIGN        = 1 << ALIGN_BITS;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [STALL_W-1:0] stall = '0;
  logic               if_ready_i = 1'b1;
  logic               flush_i = 1'b0;
  logic [ADDR_W-1:0]  new_pc_i = '0;
  logic               branch_flag_i = 1'b0;
  logic [ADDR_W-1:0]  branch_target_i = '0;
  logic [ADDR_W-1:0]  pc_o;
  logic               ce_o;
  logic               misalign_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the fetch address, whether fetching has started, the
  // misalign pulse, and a queue holding at most one deferred redirect
  logic [31:0] m_pc;
  bit          m_ce;
  bit          m_mis;
  logic [31:0] pend_q[$];

  pc_gen #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR),
    .PC_INC       (PC_INC),
    .STALL_W      (STALL_W),
    .ALIGN_BITS   (ALIGN_BITS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .if_ready_i      (if_ready_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_o),
    .ce_o            (ce_o),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alignDown(input logic [31:0] a);
    return a - (a % ALIGN);
  endfunction

  function automatic bit isMisaligned(input logic [31:0] a);
    return (a % ALIGN) != 0;
  endfunction

  task automatic modelReset();
    m_pc  = RESET_VECTOR;
    m_ce  = 1'b0;
    m_mis = 1'b0;
    pend_q.delete();
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic modelStep();
    bit adv;
    adv   = m_ce && !stall[0] && if_ready_i;
    m_mis = 1'b0;
    if (!m_ce) begin
      m_ce = 1'b1;
    end else if (flush_i) begin
      m_pc  = alignDown(new_pc_i);
      m_mis = isMisaligned(new_pc_i);
      pend_q.delete();
    end else if (branch_flag_i && adv) begin
      m_pc  = alignDown(branch_target_i);
      m_mis = isMisaligned(branch_target_i);
      pend_q.delete();
    end else if (branch_flag_i) begin
      pend_q.delete();
      pend_q.push_back(alignDown(branch_target_i));
      m_mis = isMisaligned(branch_target_i);
    end else if (pend_q.size() != 0 && adv) begin
      m_pc = pend_q.pop_front();
    end else if (adv) begin
      m_pc = m_pc + PC_INC;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_pc"}, pc_o, m_pc);
    checkOutput({tag, "_ce"}, {31'd0, ce_o}, {31'd0, m_ce});
    checkOutput({tag, "_mis"}, {31'd0, misalign_o}, {31'd0, m_mis});
  endtask

  // Drive one cycle of inputs, step the model, and compare after the edge
  task automatic applyStimulus(input string tag, input bit st, input bit rdy,
                               input bit fl, input logic [31:0] npc,
                               input bit br, input logic [31:0] tgt);
    stall           = {5'($urandom), st};
    if_ready_i      = rdy;
    flush_i         = fl;
    new_pc_i        = npc;
    branch_flag_i   = br;
    branch_target_i = tgt;
    modelStep();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset pulse spanning one rising edge
  task automatic pulseReset(input string tag);
    rst = 1'b1;
    #1;
    modelReset();
    checkAll({tag, "_async"});
    @(posedge clk);
    #1;
    checkAll({tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    // T1: reset state, then enable and sequential fetch
    #1;
    checkAll("t1_rst");
    checkOutput("t1_rst_pc_const", pc_o, RESET_VECTOR);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("t1", 4);
    checkOutput("t1_pc_c", pc_o, 32'hC);

    // T2: freeze at 0x10 for three cycles, then step once
    idle("t2_pre", 1);
    for (int i = 0; i < 3; i++) applyStimulus("t2_stall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t2_hold", pc_o, 32'h10);
    idle("t2_rel", 1);
    checkOutput("t2_step", pc_o, 32'h14);

    // T3: branch while stalled at 0x20 is captured, then taken on release
    idle("t3_pre", 3);
    applyStimulus("t3_br", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
    applyStimulus("t3_stall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t3_hold", pc_o, 32'h20);
    idle("t3_rel", 1);
    checkOutput("t3_tgt", pc_o, 32'h100);
    idle("t3_seq", 1);
    checkOutput("t3_next", pc_o, 32'h104);

    // T4: flush beats a same-cycle branch even with the ROM not ready
    applyStimulus("t4_fl", 1'b0, 1'b0, 1'b1, 32'h180, 1'b1, 32'h200);
    checkOutput("t4_flush", pc_o, 32'h180);
    idle("t4_post", 3);
    checkOutput("t4_no_br", pc_o, 32'h18C);

    // T5: misaligned branch target and adder wrap-around
    applyStimulus("t5_br", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h103);
    checkOutput("t5_tgt", pc_o, 32'h100);
    checkOutput("t5_mis_on", {31'd0, misalign_o}, 32'd1);
    idle("t5_seq", 1);
    checkOutput("t5_mis_off", {31'd0, misalign_o}, 32'd0);
    applyStimulus("t5_fl", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    idle("t5_wrap", 1);
    checkOutput("t5_wrap_pc", pc_o, 32'h0);

    // T6: reset while a redirect is pending discards it
    applyStimulus("t6_br", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
    #3;
    pulseReset("t6");
    checkOutput("t6_rst_ce", {31'd0, ce_o}, 32'd0);
    idle("t6_post", 4);
    checkOutput("t6_no_pend", pc_o, RESET_VECTOR + 32'(3 * PC_INC));

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        pulseReset("rnd_rst");
      end else begin
        applyStimulus("rnd",
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 15) == 0,
                      $urandom,
                      $urandom_range(0, 4) == 0,
                      $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
